// File: rtl/cpu_trace_emitter.sv
// Serialises one CPU write-back record (register or memory write) as an ASCII trace line,
// one character per accepted beat: "^T@PPPPPPPP: $R <= DDDDDDDD#" or "...: *AAAAAAAA <= ...#".
module cpu_trace_emitter #(
    parameter bit          UPPER_HEX = 1'b0,
    parameter int unsigned MAX_TIME  = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_kind,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_idx,
    input  logic [31:0] in_data,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

    localparam logic [13:0] MAX_T = 14'(MAX_TIME);

    state_t      state;
    logic        kind;
    logic [31:0] pc;
    logic [31:0] idx;
    logic [31:0] data;
    logic [29:0] dd;
    logic [3:0]  cnt;
    logic [5:0]  pos;

    logic [13:0] tsat;
    logic [5:0]  nxt_pos;
    logic [7:0]  nxt_char;
    logic [3:0]  d3, d2, d1, d0;
    logic [3:0]  reg_tens, reg_units;
    logic [4:0]  reg_rem;
    logic [2:0]  pc_sel, idx_sel, data_sel;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] n);
        return 8'h30 + {4'h0, n};
    endfunction

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift the whole register left.
    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] r;
        r = v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r[14 + 4*i +: 4] >= 4'd5)
                r[14 + 4*i +: 4] = r[14 + 4*i +: 4] + 4'd3;
        end
        return {r[28:0], 1'b0};
    endfunction

    assign tsat = (in_time > MAX_T) ? MAX_T : in_time;
    assign d3 = dd[29:26];
    assign d2 = dd[25:22];
    assign d1 = dd[21:18];
    assign d0 = dd[17:14];

    always_comb begin
        reg_tens = 4'd0;
        reg_rem  = idx[4:0];
        if (idx[4:0] >= 5'd30) begin
            reg_tens = 4'd3;
            reg_rem  = idx[4:0] - 5'd30;
        end else if (idx[4:0] >= 5'd20) begin
            reg_tens = 4'd2;
            reg_rem  = idx[4:0] - 5'd20;
        end else if (idx[4:0] >= 5'd10) begin
            reg_tens = 4'd1;
            reg_rem  = idx[4:0] - 5'd10;
        end
        reg_units = reg_rem[3:0];
    end

    // Character positions: 0 '^', 1-4 time digits, 5 '@', 6-13 pc, 14 ':', 15 ' ', 16 '$'/'*',
    // 17-24 address, 25-26 register digits, 27-30 " <= ", 31-38 data, 39 '#'.
    always_comb begin
        nxt_pos = pos + 6'd1;
        case (pos)
            6'd0: begin
                if (d3 != 4'd0)      nxt_pos = 6'd1;
                else if (d2 != 4'd0) nxt_pos = 6'd2;
                else if (d1 != 4'd0) nxt_pos = 6'd3;
                else                 nxt_pos = 6'd4;
            end
            6'd16: begin
                if (kind)                   nxt_pos = 6'd17;
                else if (idx[4:0] >= 5'd10) nxt_pos = 6'd25;
                else                        nxt_pos = 6'd26;
            end
            6'd24:   nxt_pos = 6'd27;
            default: nxt_pos = pos + 6'd1;
        endcase
    end

    always_comb begin
        pc_sel   = 3'(6'd13 - nxt_pos);
        idx_sel  = 3'(6'd24 - nxt_pos);
        data_sel = 3'(6'd38 - nxt_pos);
        nxt_char = 8'h23;
        if (nxt_pos == 6'd0)                 nxt_char = 8'h5e;
        else if (nxt_pos == 6'd1)            nxt_char = dec_char(d3);
        else if (nxt_pos == 6'd2)            nxt_char = dec_char(d2);
        else if (nxt_pos == 6'd3)            nxt_char = dec_char(d1);
        else if (nxt_pos == 6'd4)            nxt_char = dec_char(d0);
        else if (nxt_pos == 6'd5)            nxt_char = 8'h40;
        else if (nxt_pos inside {[6:13]})    nxt_char = hex_char(pc[{pc_sel, 2'b00} +: 4]);
        else if (nxt_pos == 6'd14)           nxt_char = 8'h3a;
        else if (nxt_pos == 6'd15)           nxt_char = 8'h20;
        else if (nxt_pos == 6'd16)           nxt_char = kind ? 8'h2a : 8'h24;
        else if (nxt_pos inside {[17:24]})   nxt_char = hex_char(idx[{idx_sel, 2'b00} +: 4]);
        else if (nxt_pos == 6'd25)           nxt_char = dec_char(reg_tens);
        else if (nxt_pos == 6'd26)           nxt_char = dec_char(reg_units);
        else if (nxt_pos == 6'd27)           nxt_char = 8'h20;
        else if (nxt_pos == 6'd28)           nxt_char = 8'h3c;
        else if (nxt_pos == 6'd29)           nxt_char = 8'h3d;
        else if (nxt_pos == 6'd30)           nxt_char = 8'h20;
        else if (nxt_pos inside {[31:38]})   nxt_char = hex_char(data[{data_sel, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            char_valid <= 1'b0;
            char_out   <= 8'h00;
            busy       <= 1'b0;
            kind       <= 1'b0;
            pc         <= '0;
            idx        <= '0;
            data       <= '0;
            dd         <= '0;
            cnt        <= '0;
            pos        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        kind     <= in_kind;
                        pc       <= in_pc;
                        idx      <= in_idx;
                        data     <= in_data;
                        dd       <= {16'h0000, tsat};
                        cnt      <= '0;
                        state    <= CONV;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    dd  <= dd_step(dd);
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd13) begin
                        state      <= EMIT;
                        char_out   <= 8'h5e;
                        char_valid <= 1'b1;
                        pos        <= '0;
                    end
                end
                EMIT: begin
                    if (char_ready) begin
                        if (pos == 6'd39) begin
                            char_valid <= 1'b0;
                            state      <= IDLE;
                            in_ready   <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            pos      <= nxt_pos;
                            char_out <= nxt_char;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready   <= 1'b1;
                    char_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: directed vector table, multi-cycle corner sequences and
// randomized records compared against a string-formatting reference model.
module tb_cpu_trace_emitter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_kind = 1'b0;
    logic [13:0] in_time = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_idx = '0;
    logic [31:0] in_data = '0;
    logic        char_ready = 1'b1;
    logic        in_ready, char_valid, busy;
    logic [7:0]  char_out;
    logic        in_ready_u, char_valid_u, busy_u;
    logic [7:0]  char_out_u;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_trace_emitter #(.UPPER_HEX(1'b0), .MAX_TIME(9999)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_time(in_time), .in_pc(in_pc), .in_idx(in_idx),
        .in_data(in_data), .char_out(char_out), .char_valid(char_valid),
        .char_ready(char_ready), .busy(busy)
    );

    cpu_trace_emitter #(.UPPER_HEX(1'b1), .MAX_TIME(9999)) u_up (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_kind(in_kind), .in_time(in_time), .in_pc(in_pc), .in_idx(in_idx),
        .in_data(in_data), .char_out(char_out_u), .char_valid(char_valid_u),
        .char_ready(char_ready), .busy(busy_u)
    );

    typedef struct {
        logic        kind;
        logic [13:0] t;
        logic [31:0] pc;
        logic [31:0] idx;
        logic [31:0] data;
        string       exp;
    } vec_t;

    vec_t vecs[7];

    function automatic string model(input logic kind, input logic [13:0] t, input logic [31:0] pc,
                                    input logic [31:0] idx, input logic [31:0] data);
        int          tt;
        logic [4:0]  r;
        string       s;
        tt = (int'(t) > 9999) ? 9999 : int'(t);
        r  = idx[4:0];
        s  = $sformatf("^%0d@%08x: ", tt, pc);
        if (kind) s = {s, $sformatf("*%08x", idx)};
        else      s = {s, $sformatf("$%0d", r)};
        s = {s, $sformatf(" <= %08x#", data)};
        return s;
    endfunction

    task automatic check(input bit ok, input string name, input string act, input string req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        in_kind = v.kind;
        in_time = v.t;
        in_pc   = v.pc;
        in_idx  = v.idx;
        in_data = v.data;
    endtask

    task automatic send(input vec_t v, input bit hold, output int lat);
        int g;
        @(negedge clk);
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check(in_ready == 1'b1, "ready_wait", $sformatf("%0b", in_ready), "1");
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check(!in_ready && busy, "accept", $sformatf("ready=%0b busy=%0b", in_ready, busy), "ready=0 busy=1");
        if (!hold) begin
            in_valid = 1'b0;
            in_kind  = 1'($urandom);
            in_time  = 14'($urandom);
            in_pc    = $urandom;
            in_idx   = $urandom;
            in_data  = $urandom;
        end
        lat = 0;
        while (!char_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic collect(input bit bp, input int stop_after, output string s, output string su);
        bit         pend;
        logic [7:0] held;
        int         beats;
        pend  = 1'b0;
        held  = 8'h00;
        beats = 0;
        s     = "";
        su    = "";
        for (int g = 0; g < 600; g++) begin
            @(negedge clk);
            if (pend)
                check(char_valid && char_out == held, "stall_stable",
                      $sformatf("v=%0b c=%02h", char_valid, char_out), $sformatf("v=1 c=%02h", held));
            if (bp) begin
                check(!in_ready, "busy_no_accept", $sformatf("%0b", in_ready), "0");
                in_valid = 1'($urandom_range(0, 1));
                in_kind  = 1'($urandom);
                in_time  = 14'($urandom);
                in_pc    = $urandom;
                in_idx   = $urandom;
                in_data  = $urandom;
            end
            if (char_valid) begin
                char_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (char_ready) begin
                    s  = {s, $sformatf("%c", char_out)};
                    su = {su, $sformatf("%c", char_out_u)};
                    beats++;
                    pend = 1'b0;
                    if (char_out == 8'h23) begin
                        @(negedge clk);
                        if (bp) in_valid = 1'b0;
                        char_ready = 1'b1;
                        check(!char_valid, "valid_drop", $sformatf("%0b", char_valid), "0");
                        check(in_ready, "ready_rise", $sformatf("%0b", in_ready), "1");
                        return;
                    end
                    if (stop_after != 0 && beats == stop_after) return;
                end else begin
                    pend = 1'b1;
                    held = char_out;
                end
            end
        end
        check(char_out == 8'h23, "line_timeout", s, "complete line ending in #");
        in_valid   = 1'b0;
        char_ready = 1'b1;
    endtask

    initial begin
        string s, su, s1, s2, e;
        int    lat, gap;
        vec_t  v;

        vecs[0] = '{1'b0, 14'd242,   32'h00003f04, 32'd31,        32'h12321589, "^242@00003f04: $31 <= 12321589#"};
        vecs[1] = '{1'b1, 14'd338,   32'h00003130, 32'h00000088,  32'hffffb528, "^338@00003130: *00000088 <= ffffb528#"};
        vecs[2] = '{1'b0, 14'd0,     32'h00000000, 32'd5,         32'hdeadbeef, "^0@00000000: $5 <= deadbeef#"};
        vecs[3] = '{1'b0, 14'd15000, 32'h12345678, 32'd10,        32'h00000000, "^9999@12345678: $10 <= 00000000#"};
        vecs[4] = '{1'b0, 14'd9,     32'h0000a5b6, 32'hffffffe7,  32'h0f0f0f0f, "^9@0000a5b6: $7 <= 0f0f0f0f#"};
        vecs[5] = '{1'b1, 14'd9999,  32'hffffffff, 32'h00000000,  32'h00000000, "^9999@ffffffff: *00000000 <= 00000000#"};
        vecs[6] = '{1'b0, 14'd100,   32'h00000001, 32'd9,         32'h00000010, "^100@00000001: $9 <= 00000010#"};

        #12;
        check(in_ready && !char_valid && char_out == 8'h00 && !busy, "reset_state",
              $sformatf("rdy=%0b v=%0b c=%02h busy=%0b", in_ready, char_valid, char_out, busy),
              "rdy=1 v=0 c=00 busy=0");
        @(negedge clk);
        reset = 1'b1;

        // Directed table, char_ready held high
        for (int i = 0; i < 7; i++) begin
            send(vecs[i], 1'b0, lat);
            check(lat == 14, $sformatf("latency_%0d", i), $sformatf("%0d", lat), "14");
            collect(1'b0, 0, s, su);
            check(s == vecs[i].exp, $sformatf("line_%0d", i), s, vecs[i].exp);
            e = vecs[i].exp.toupper();
            check(su == e, $sformatf("upper_%0d", i), su, e);
        end
        check(vecs[2].exp.len() == 28, "min_reg_len_table", $sformatf("%0d", vecs[2].exp.len()), "28");

        // Backpressure with in_valid pulses while busy
        send(vecs[0], 1'b0, lat);
        collect(1'b1, 0, s, su);
        check(s == vecs[0].exp, "backpressure_line", s, vecs[0].exp);

        // Reset asserted mid-line, checked between clock edges
        send(vecs[1], 1'b0, lat);
        collect(1'b0, 10, s, su);
        e = vecs[1].exp.substr(0, 9);
        check(s == e, "partial_line", s, e);
        #2;
        reset = 1'b0;
        #1;
        check(!char_valid && in_ready && !busy, "async_reset",
              $sformatf("v=%0b rdy=%0b busy=%0b", char_valid, in_ready, busy), "v=0 rdy=1 busy=0");
        @(negedge clk);
        reset = 1'b1;
        send(vecs[6], 1'b0, lat);
        check(lat == 14, "latency_after_reset", $sformatf("%0d", lat), "14");
        collect(1'b0, 0, s, su);
        check(s == vecs[6].exp, "line_after_reset", s, vecs[6].exp);

        // Back-to-back records with in_valid held high
        send(vecs[0], 1'b1, lat);
        drive(vecs[1]);
        collect(1'b0, 0, s1, su);
        gap = 0;
        while (!char_valid && gap < 40) begin
            @(posedge clk);
            gap++;
            #1;
            if (gap == 1) begin
                check(!in_ready, "b2b_accept", $sformatf("%0b", in_ready), "0");
                in_valid = 1'b0;
            end
        end
        check(gap == 15, "b2b_gap", $sformatf("%0d", gap), "15");
        collect(1'b0, 0, s2, su);
        e = {vecs[0].exp, vecs[1].exp};
        check({s1, s2} == e, "b2b_stream", {s1, s2}, e);
        check(s1.substr(15, 15) == "$" && s2.substr(15, 15) == "*", "b2b_types",
              {s1.substr(15, 15), s2.substr(15, 15)}, "$*");

        // Randomized records against the reference model
        for (int n = 0; n < 30; n++) begin
            v.kind = 1'($urandom);
            v.t    = 14'($urandom_range(0, 16383));
            if (n % 5 == 0) v.t = 14'($urandom_range(0, 9));
            v.pc   = $urandom;
            v.idx  = $urandom;
            v.data = $urandom;
            v.exp  = model(v.kind, v.t, v.pc, v.idx, v.data);
            send(v, 1'b0, lat);
            check(lat == 14, $sformatf("rnd_latency_%0d", n), $sformatf("%0d", lat), "14");
            collect(1'($urandom), 0, s, su);
            check(s == v.exp, $sformatf("rnd_line_%0d", n), s, v.exp);
            e = v.exp.toupper();
            check(su == e, $sformatf("rnd_upper_%0d", n), su, e);
            if (v.kind)
                check(s.len() >= 35 && s.len() <= 38, $sformatf("rnd_len_%0d", n), $sformatf("%0d", s.len()), "35..38");
            else
                check(s.len() >= 28 && s.len() <= 32, $sformatf("rnd_len_%0d", n), $sformatf("%0d", s.len()), "28..32");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
